// File: rtl/ps2_rx_frame_pkg.sv
// ps2_rx_frame_pkg: shared PS/2 receiver definitions.
// Holds the keyboard code constants, the frame length, the receiver FSM encoding
// and the odd-parity helper used by the frame checker.
package ps2_rx_frame_pkg;

    localparam logic [7:0] PS2_BAT_OK    = 8'hAA;
    localparam logic [7:0] PS2_BAT_FAIL  = 8'hFC;
    localparam logic [7:0] PS2_EXT       = 8'hE0;
    localparam logic [7:0] PS2_BREAK     = 8'hF0;
    localparam logic [7:0] PS2_RESET_CMD = 8'hFF;

    localparam int PS2_FRAME_BITS = 11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_CHECK = 2'd2
    } rx_state_t;

    // Odd parity: data bits plus parity bit must hold an odd number of ones.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic parity);
        return ^{data, parity};
    endfunction

endpackage

// File: rtl/ps2_rx_frame_if.sv
// ps2_rx_frame_if: raw PS/2 lines, host bus-ownership flag and decoded results.
// master: the receiver (samples the lines, drives results).
// slave:  the consumer of received bytes.
// Optional prefix outputs exist only when PS2_RX_PREFIX_DECODE_EN is defined.
interface ps2_rx_frame_if;
    import ps2_rx_frame_pkg::*;

    logic       ps2_clk;
    logic       ps2_data;
    logic       host_busy;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       parity_err;
    logic       frame_err;
    logic       bat_ok;
    logic       bat_fail;
`ifdef PS2_RX_PREFIX_DECODE_EN
    logic       rx_ext;
    logic       rx_break;

    modport master (
        input  ps2_clk, ps2_data, host_busy,
        output rx_data, rx_valid, parity_err, frame_err, bat_ok, bat_fail, rx_ext, rx_break
    );
    modport slave (
        output ps2_clk, ps2_data, host_busy,
        input  rx_data, rx_valid, parity_err, frame_err, bat_ok, bat_fail, rx_ext, rx_break
    );
`else
    modport master (
        input  ps2_clk, ps2_data, host_busy,
        output rx_data, rx_valid, parity_err, frame_err, bat_ok, bat_fail
    );
    modport slave (
        output ps2_clk, ps2_data, host_busy,
        input  rx_data, rx_valid, parity_err, frame_err, bat_ok, bat_fail
    );
`endif
endinterface

// File: rtl/ps2_rx_frame_line_filter.sv
// ps2_rx_frame_line_filter: 2-FF synchronisers for ps2_clk and ps2_data, a
// glitch filter on ps2_clk and a registered falling-edge strobe. The filtered
// clock only changes after FILTER_LEN consecutive samples at the new level.
module ps2_rx_frame_line_filter #(
    parameter int FILTER_LEN = 8,
    parameter int FILTER_W   = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic line_clk,
    input  logic line_data,
    output logic data_sync,
    output logic fall
);
    logic [1:0]          clk_ff;
    logic [1:0]          data_ff;
    logic                clk_filt;
    logic [FILTER_W-1:0] stable_cnt;

    // Synchronise both raw lines; reset to the idle-high bus level.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk_ff  <= 2'b11;
            data_ff <= 2'b11;
        end else begin
            clk_ff  <= {clk_ff[0], line_clk};
            data_ff <= {data_ff[0], line_data};
        end
    end

    assign data_sync = data_ff[1];

    // Commit a new ps2_clk level after FILTER_LEN differing samples; flag 1->0 commits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk_filt   <= 1'b1;
            stable_cnt <= '0;
            fall       <= 1'b0;
        end else begin
            fall <= 1'b0;
            if (clk_ff[1] == clk_filt) begin
                stable_cnt <= '0;
            end else if (stable_cnt == FILTER_W'(FILTER_LEN - 1)) begin
                clk_filt   <= clk_ff[1];
                stable_cnt <= '0;
                fall       <= clk_filt;
            end else begin
                stable_cnt <= stable_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_rx_frame.sv
// ps2_rx_frame: host-side PS/2 device-to-host frame receiver.
// Deserialises start/8 data/odd parity/stop frames, flags parity and framing
// errors, decodes BAT pass/fail codes and stays silent while the host owns the bus.
// Optional: PS2_RX_PREFIX_DECODE_EN folds E0/F0 prefixes into rx_ext/rx_break.
module ps2_rx_frame
    import ps2_rx_frame_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int FILTER_W       = 4,
    parameter int TIMEOUT_CYCLES = 10000,
    parameter int TIMEOUT_W      = 14
) (
    input  logic          clk,
    input  logic          rst,
    ps2_rx_frame_if.master bus
);
    logic                 data_s;
    logic                 fall;
    rx_state_t            state;
    logic [3:0]           bitcnt;
    logic [7:0]           shift;
    logic                 par_bit;
    logic                 stop_bit;
    logic [TIMEOUT_W-1:0] tcnt;
    logic [7:0]           rx_data;
    logic                 rx_valid;
    logic                 parity_err;
    logic                 frame_err;
    logic                 bat_ok;
    logic                 bat_fail;
    logic                 par_good;
`ifdef PS2_RX_PREFIX_DECODE_EN
    logic                 ext_flag;
    logic                 brk_flag;
    logic                 rx_ext;
    logic                 rx_break;
`endif

    ps2_rx_frame_line_filter #(
        .FILTER_LEN (FILTER_LEN),
        .FILTER_W   (FILTER_W)
    ) u_filter (
        .clk       (clk),
        .rst       (rst),
        .line_clk  (bus.ps2_clk),
        .line_data (bus.ps2_data),
        .data_sync (data_s),
        .fall      (fall)
    );

    assign par_good = odd_parity_ok(shift, par_bit);

    // Frame FSM: shift bits on filtered falls, check the frame, register result pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            bitcnt     <= '0;
            shift      <= '0;
            par_bit    <= 1'b0;
            stop_bit   <= 1'b0;
            tcnt       <= '0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            bat_ok     <= 1'b0;
            bat_fail   <= 1'b0;
`ifdef PS2_RX_PREFIX_DECODE_EN
            ext_flag   <= 1'b0;
            brk_flag   <= 1'b0;
            rx_ext     <= 1'b0;
            rx_break   <= 1'b0;
`endif
        end else begin
            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            bat_ok     <= 1'b0;
            bat_fail   <= 1'b0;
`ifdef PS2_RX_PREFIX_DECODE_EN
            rx_ext     <= 1'b0;
            rx_break   <= 1'b0;
`endif
            if (bus.host_busy) begin
                // Host owns the bus: drop any partial frame without reporting it.
                state  <= ST_IDLE;
                bitcnt <= '0;
                shift  <= '0;
                tcnt   <= '0;
`ifdef PS2_RX_PREFIX_DECODE_EN
                ext_flag <= 1'b0;
                brk_flag <= 1'b0;
`endif
            end else begin
                case (state)
                    ST_IDLE: begin
                        tcnt <= '0;
                        if (fall && !data_s) begin
                            bitcnt <= 4'd1;
                            state  <= ST_SHIFT;
                        end
                    end
                    ST_SHIFT: begin
                        if (fall) begin
                            tcnt   <= '0;
                            bitcnt <= bitcnt + 4'd1;
                            if (bitcnt < 4'd9) begin
                                shift <= {data_s, shift[7:1]};
                            end else if (bitcnt == 4'd9) begin
                                par_bit <= data_s;
                            end else begin
                                stop_bit <= data_s;
                                state    <= ST_CHECK;
                            end
                        end else if (tcnt == TIMEOUT_W'(TIMEOUT_CYCLES - 1)) begin
                            frame_err <= 1'b1;
                            state     <= ST_IDLE;
                            bitcnt    <= '0;
                            tcnt      <= '0;
`ifdef PS2_RX_PREFIX_DECODE_EN
                            ext_flag  <= 1'b0;
                            brk_flag  <= 1'b0;
`endif
                        end else begin
                            tcnt <= tcnt + 1'b1;
                        end
                    end
                    ST_CHECK: begin
                        state  <= ST_IDLE;
                        bitcnt <= '0;
                        if (par_good && stop_bit) begin
`ifdef PS2_RX_PREFIX_DECODE_EN
                            if (shift == PS2_EXT) begin
                                ext_flag <= 1'b1;
                            end else if (shift == PS2_BREAK) begin
                                brk_flag <= 1'b1;
                            end else begin
                                rx_data  <= shift;
                                rx_valid <= 1'b1;
                                bat_ok   <= (shift == PS2_BAT_OK);
                                bat_fail <= (shift == PS2_BAT_FAIL);
                                rx_ext   <= ext_flag;
                                rx_break <= brk_flag;
                                ext_flag <= 1'b0;
                                brk_flag <= 1'b0;
                            end
`else
                            rx_data  <= shift;
                            rx_valid <= 1'b1;
                            bat_ok   <= (shift == PS2_BAT_OK);
                            bat_fail <= (shift == PS2_BAT_FAIL);
`endif
                        end else begin
                            parity_err <= !par_good;
                            frame_err  <= !stop_bit;
`ifdef PS2_RX_PREFIX_DECODE_EN
                            ext_flag   <= 1'b0;
                            brk_flag   <= 1'b0;
`endif
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    assign bus.rx_data    = rx_data;
    assign bus.rx_valid   = rx_valid;
    assign bus.parity_err = parity_err;
    assign bus.frame_err  = frame_err;
    assign bus.bat_ok     = bat_ok;
    assign bus.bat_fail   = bat_fail;
`ifdef PS2_RX_PREFIX_DECODE_EN
    assign bus.rx_ext     = rx_ext;
    assign bus.rx_break   = rx_break;
`endif

endmodule

// File: tb/tb_ps2_rx_frame.sv
// tb_ps2_rx_frame: scoreboard bench for ps2_rx_frame. Frames are driven with a
// shortened bit period and timeout; each driven frame pushes its expected result
// pulse, and a monitor pops and compares whenever the receiver pulses.
// Honours PS2_RX_PREFIX_DECODE_EN for the prefix scenario.
module tb_ps2_rx_frame;

    localparam int HALF      = 40;
    localparam int TIMEOUT   = 400;
    localparam int TIMEOUT_W = 10;

    typedef struct {
        logic [7:0] data;
        logic       valid;
        logic       perr;
        logic       ferr;
        logic       bok;
        logic       bfail;
        logic       ext;
        logic       brk;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t exp_q[$];
    exp_t mon_e;
    logic [7:0] last_data = 8'h00;
    logic m_ext = 1'b0;
    logic m_brk = 1'b0;

    ps2_rx_frame_if bus();

    ps2_rx_frame #(
        .FILTER_LEN     (8),
        .FILTER_W       (4),
        .TIMEOUT_CYCLES (TIMEOUT),
        .TIMEOUT_W      (TIMEOUT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Compare every result pulse against the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst && (bus.rx_valid || bus.parity_err || bus.frame_err || bus.bat_ok || bus.bat_fail)) begin
            if (exp_q.size() == 0) begin
                check_val("unexpected_pulse", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                check_val("rx_valid",   bus.rx_valid,   mon_e.valid);
                check_val("parity_err", bus.parity_err, mon_e.perr);
                check_val("frame_err",  bus.frame_err,  mon_e.ferr);
                check_val("bat_ok",     bus.bat_ok,     mon_e.bok);
                check_val("bat_fail",   bus.bat_fail,   mon_e.bfail);
                check_val("rx_data",    bus.rx_data,    mon_e.data);
`ifdef PS2_RX_PREFIX_DECODE_EN
                check_val("rx_ext",     bus.rx_ext,     mon_e.ext);
                check_val("rx_break",   bus.rx_break,   mon_e.brk);
`endif
            end
        end
    end

    function automatic logic [10:0] mk_frame(input logic [7:0] b, input logic p, input logic s);
        return {s, p, b, 1'b0};
    endfunction

    // Reference model of one received frame; pushes the pulse it should cause.
    task automatic expect_frame(input logic [7:0] b, input logic p, input logic s);
        exp_t e;
        int   ones;
        logic par_ok;
        ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(b[i]);
        ones += int'(p);
        par_ok = (ones % 2) == 1;
        e = '{data: 8'h00, valid: 1'b0, perr: 1'b0, ferr: 1'b0, bok: 1'b0, bfail: 1'b0, ext: 1'b0, brk: 1'b0};
        if (par_ok && s) begin
`ifdef PS2_RX_PREFIX_DECODE_EN
            if (b == 8'hE0) begin m_ext = 1'b1; return; end
            if (b == 8'hF0) begin m_brk = 1'b1; return; end
            e.ext = m_ext;
            e.brk = m_brk;
            m_ext = 1'b0;
            m_brk = 1'b0;
`endif
            last_data = b;
            e.valid = 1'b1;
            e.bok   = (b == 8'hAA);
            e.bfail = (b == 8'hFC);
        end else begin
            e.perr = !par_ok;
            e.ferr = !s;
            m_ext  = 1'b0;
            m_brk  = 1'b0;
        end
        e.data = last_data;
        exp_q.push_back(e);
    endtask

    task automatic expect_timeout();
        exp_t e;
        e = '{data: last_data, valid: 1'b0, perr: 1'b0, ferr: 1'b1, bok: 1'b0, bfail: 1'b0, ext: 1'b0, brk: 1'b0};
        m_ext = 1'b0;
        m_brk = 1'b0;
        exp_q.push_back(e);
    endtask

    // Device-side bit driver; optional 3-cycle low glitch in one bit's high phase.
    task automatic drive_bits(input logic [10:0] f, input int n, input int glitch);
        for (int i = 0; i < n; i++) begin
            bus.ps2_data = f[i];
            if (i == glitch) begin
                repeat (10) @(negedge clk);
                bus.ps2_clk = 1'b0;
                repeat (3) @(negedge clk);
                bus.ps2_clk = 1'b1;
                repeat (HALF - 13) @(negedge clk);
            end else begin
                repeat (HALF) @(negedge clk);
            end
            bus.ps2_clk = 1'b0;
            repeat (HALF) @(negedge clk);
            bus.ps2_clk = 1'b1;
        end
        bus.ps2_data = 1'b1;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
        #1;
        check_val("queue_drained", exp_q.size(), 0);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic p, input logic s, input int glitch);
        expect_frame(b, p, s);
        drive_bits(mk_frame(b, p, s), 11, glitch);
        repeat (2 * HALF) @(negedge clk);
        wait_drain();
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_rx_data"},    bus.rx_data,    0);
        check_val({tag, "_rx_valid"},   bus.rx_valid,   0);
        check_val({tag, "_parity_err"}, bus.parity_err, 0);
        check_val({tag, "_frame_err"},  bus.frame_err,  0);
        check_val({tag, "_bat_ok"},     bus.bat_ok,     0);
        check_val({tag, "_bat_fail"},   bus.bat_fail,   0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen;
        bus.ps2_clk   = 1'b1;
        bus.ps2_data  = 1'b1;
        bus.host_busy = 1'b0;
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b1;
        repeat (10) @(negedge clk);

        // Idle glitch and an idle fall with data high: both ignored.
        bus.ps2_clk = 1'b0;
        repeat (3) @(negedge clk);
        bus.ps2_clk = 1'b1;
        repeat (20) @(negedge clk);
        drive_bits(11'h7FF, 1, -1);
        repeat (2 * HALF) @(negedge clk);

        // Good frames and BAT codes.
        send_frame(8'h1C, 1'b0, 1'b1, -1);
        send_frame(8'hAA, 1'b1, 1'b1, -1);
        send_frame(8'hFC, 1'b1, 1'b1, -1);

        // Parity, stop and combined errors.
        send_frame(8'h1C, 1'b1, 1'b1, -1);
        send_frame(8'h1C, 1'b0, 1'b0, -1);
        send_frame(8'h1C, 1'b1, 1'b0, -1);

        // Mid-frame glitch must not consume a bit.
        send_frame(8'h5A, 1'b1, 1'b1, 4);

        // Stall after bit 5 times out; next frame is clean.
        expect_timeout();
        drive_bits(mk_frame(8'h33, 1'b1, 1'b1), 6, -1);
        repeat (TIMEOUT + 200) @(negedge clk);
        wait_drain();
        send_frame(8'h29, 1'b0, 1'b1, -1);

        // Host takes the bus after bit 4: partial frame discarded silently.
        drive_bits(mk_frame(8'h55, 1'b1, 1'b1), 5, -1);
        bus.host_busy = 1'b1;
        repeat (5) @(negedge clk);
        bus.host_busy = 1'b0;
        repeat (2 * HALF) @(negedge clk);
        send_frame(8'hAA, 1'b1, 1'b1, -1);

        // Back-to-back frames.
        send_frame(8'h12, 1'b1, 1'b1, -1);
        send_frame(8'h34, 1'b0, 1'b1, -1);

        // Prefix handling (or plain delivery of prefixes when disabled).
        send_frame(8'hE0, 1'b0, 1'b1, -1);
        send_frame(8'hF0, 1'b1, 1'b1, -1);
        send_frame(8'h75, 1'b0, 1'b1, -1);
        send_frame(8'h75, 1'b0, 1'b1, -1);

        // Reset mid-frame clears rx_data immediately.
        drive_bits(mk_frame(8'h66, 1'b1, 1'b1), 5, -1);
        rst = 1'b0;
        #1;
        check_all_zero("rst_midframe");
        last_data = 8'h00;
        m_ext = 1'b0;
        m_brk = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (2 * HALF) @(negedge clk);

        // Reset while a result pulse is high kills it at once.
        expect_frame(8'hAA, 1'b1, 1'b1);
        drive_bits(mk_frame(8'hAA, 1'b1, 1'b1), 10, -1);
        bus.ps2_data = 1'b1;
        repeat (HALF) @(negedge clk);
        bus.ps2_clk = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            seen = bus.rx_valid;
        end
        check_val("pulse_seen", seen, 1);
        #1;
        rst = 1'b0;
        #1;
        check_all_zero("rst_on_pulse");
        last_data = 8'h00;
        exp_q.delete();
        @(negedge clk);
        bus.ps2_clk = 1'b1;
        rst = 1'b1;
        repeat (2 * HALF) @(negedge clk);

        // Recovery after reset.
        send_frame(8'h1C, 1'b0, 1'b1, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ps2_rx_frame.md
Name: ps2_rx_frame

Overview:
- Host-side PS/2 device-to-host receiver. Samples raw ps2_clk/ps2_data, deserialises 11-bit frames (start, 8 data LSB-first, odd parity, stop), and presents bytes with error flags.
- Decodes the keyboard BAT codes. Its bat_ok pulse drives the reset_required input of the keyboard-reset initiator.
- Goes quiet while the host owns the bus.

Parameters:
- FILTER_LEN, 8, consecutive stable clk cycles required before a ps2_clk level change is accepted.
- FILTER_W, 4, width of the filter counter. Must satisfy 2^FILTER_W > FILTER_LEN.
- TIMEOUT_CYCLES, 10000, maximum clk cycles between accepted ps2_clk falling edges inside a frame (200 us at 50 MHz).
- TIMEOUT_W, 14, width of the timeout counter.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-low reset.
- ps2_clk  input  1  raw PS/2 clock line, asynchronous to clk.
- ps2_data  input  1  raw PS/2 data line, asynchronous to clk.
- host_busy  input  1  high while the host pulls a line low (OR of the clk/data pulldowns).
- rx_data  output  8  last received byte. Held until the next frame completes.
- rx_valid  output  1  one-cycle pulse: good frame, rx_data updated.
- parity_err  output  1  one-cycle pulse: parity check failed.
- frame_err  output  1  one-cycle pulse: bad stop bit or inter-edge timeout.
- bat_ok  output  1  one-cycle pulse with rx_valid when rx_data == 8'hAA.
- bat_fail  output  1  one-cycle pulse with rx_valid when rx_data == 8'hFC.

Behaviour:
- Reset (rst low, async):
  - all outputs 0, FSM IDLE, counters 0.
  - synchroniser flops reset to 1 (idle bus).
- Input conditioning:
  - 2-FF synchroniser on each line.
  - The ps2_clk filter commits a new level only after FILTER_LEN consecutive equal samples.
  - fall = filtered ps2_clk 1->0.
  - ps2_data is sampled (synchronised) in the fall cycle.
- States:
  - IDLE, fall with data 0: start accepted, bitcnt=1, go SHIFT.
  - IDLE, fall with data 1: ignored, no error.
  - SHIFT, each fall: shift data in, bitcnt++. bitcnt 1-8 load rx shift register LSB-first, 9 = parity, 10 = stop. After stop, go CHECK.
  - SHIFT, no fall for TIMEOUT_CYCLES: frame_err pulse, go IDLE, rx_data unchanged. The timeout counter clears on every fall and in IDLE.
  - CHECK (one cycle), always returns to IDLE:
    - good: XOR(data[7:0], parity)==1 and stop==1. Load rx_data, pulse rx_valid (plus bat_ok/bat_fail if matched).
    - parity bad: parity_err pulse, rx_data unchanged.
    - stop bad (parity good): frame_err pulse, rx_data unchanged.
    - both bad: parity_err and frame_err together.
- Latency: outputs registered. The pulse appears 2 clk after the fall cycle of the stop bit.
- host_busy high: FSM forced to IDLE next cycle, bitcnt/shift/timeout cleared, no pulses. A partial frame is discarded silently. The filter keeps running.
- Pulses never stretch; back-to-back frames each yield their own pulse.
- rst mid-frame: immediate abort, no outputs.

Optional Feature:
- Macro: PS2_RX_PREFIX_DECODE_EN.
- Enabled:
  - adds outputs rx_ext (1) and rx_break (1).
  - valid bytes 8'hE0/8'hF0 set internal ext/brk flags and do not pulse rx_valid.
  - the next non-prefix valid byte pulses rx_valid with rx_ext/rx_break = flags, then flags clear.
  - flags clear on host_busy, parity/frame error, and reset.
- Disabled: ports absent, prefixes delivered as ordinary bytes.

Decomposition:
- Shared header ps2_defs.vh:
  - codes PS2_BAT_OK=8'hAA, PS2_BAT_FAIL=8'hFC, PS2_EXT=8'hE0, PS2_BREAK=8'hF0, PS2_RESET_CMD=8'hFF.
  - PS2_FRAME_BITS=11.
  - FSM state encodings.
- Sub-module ps2_line_filter: synchroniser plus glitch filter plus fall-edge detect. Instantiated for ps2_clk; its synchroniser is also used for ps2_data.

Test Plan:
- Good frame, byte 8'h1C, parity 0, stop 1, 80 us bit period -> rx_valid single pulse, rx_data=8'h1C, no errors, bat_ok=0.
- Byte 8'hAA, parity 1 -> rx_valid and bat_ok together. Byte 8'hFC -> bat_fail.
- Byte 8'h1C with parity 1 -> parity_err only, rx_data keeps prior value. Stop=0 with correct parity -> frame_err only.
- 3 clk-wide low glitches on ps2_clk in IDLE and mid-frame -> no bit consumed. Stall 250 us after bit 5 -> frame_err, IDLE, next frame 8'h29 received correctly.
- host_busy asserted after bit 4 -> no pulses, IDLE. Subsequent full frame 8'hAA -> bat_ok. rst low mid-frame -> all outputs 0 immediately.
- With PS2_RX_PREFIX_DECODE_EN: send E0 F0 75 -> one rx_valid, rx_data=8'h75, rx_ext=1, rx_break=1. Next 8'h75 -> rx_ext=rx_break=0.
